// File: rtl/lcd_hex_pager.sv
// HD44780 4-bit pager: shows a 4-word page as two lines of hex text, redrawing
// only when the selected page or its contents change.
module lcd_hex_pager #(
    parameter int NPAGE    = 4,
    parameter int INIT_CYC = 1500000,
    parameter int E_CYC    = 12,
    parameter int CMD_CYC  = 2000,
    parameter int CLR_CYC  = 80000,
    parameter int HOLD_CYC = 50000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPAGE*128-1:0]   page_data,
    input  logic [2:0]             page_sel,
    input  logic                   auto_rotate,
    output logic                   lcd_e,
    output logic                   lcd_rs,
    output logic                   lcd_rw,
    output logic [3:0]             lcd_dat,
    output logic                   busy,
    output logic [2:0]             cur_page
);

    typedef enum logic [2:0] {
        S_INIT_WAIT, S_INIT_SEQ, S_IDLE, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2
    } state_t;
    typedef enum logic [1:0] {PH_SU, PH_EH, PH_HD, PH_WT} phase_t;

    state_t         state_q, state_d, nxt_s;
    phase_t         ph_q, ph_d;
    logic [31:0]    cnt_q, cnt_d, ph_lim_s, rot_cnt_q, rot_cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic           half_q, half_d, first_q, first_d;
    logic [2:0]     cur_page_q, cur_page_d, rot_q, rot_d, eff_s;
    logic [127:0]   snap_q, snap_d, live_s;
    logic           e_q, e_d, rs_q, rs_d, busy_q, busy_d;
    logic [3:0]     dat_q, dat_d, cur_nib_s, snap_nib_s;
    logic [7:0]     cur_byte_s;
    logic [6:0]     char_off_s;
    logic           single_s, last_item_s, ph_done_s, start_s, send_s;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Current item to send: byte value, nibble-only flag, last-of-state flag, successor state
    always_comb begin
        cur_byte_s  = 8'h00;
        single_s    = 1'b0;
        last_item_s = 1'b0;
        nxt_s       = S_IDLE;
        char_off_s  = {(state_q == S_LINE2), idx_q[3], 3'd7 - idx_q[2:0], 2'b00};
        snap_nib_s  = 4'(snap_q >> char_off_s);
        case (state_q)
            S_INIT_SEQ: begin
                single_s    = ~idx_q[2];
                last_item_s = (idx_q == 4'd7);
                nxt_s       = S_IDLE;
                case (idx_q[2:0])
                    3'd0, 3'd1, 3'd2: cur_byte_s = 8'h30;
                    3'd3:             cur_byte_s = 8'h20;
                    3'd4:             cur_byte_s = 8'h28;
                    3'd5:             cur_byte_s = 8'h0C;
                    3'd6:             cur_byte_s = 8'h06;
                    default:          cur_byte_s = 8'h01;
                endcase
            end
            S_ADDR1: begin cur_byte_s = 8'h80; last_item_s = 1'b1; nxt_s = S_LINE1; end
            S_LINE1: begin
                cur_byte_s  = hex_char(snap_nib_s);
                last_item_s = (idx_q == 4'd15);
                nxt_s       = S_ADDR2;
            end
            S_ADDR2: begin cur_byte_s = 8'hC0; last_item_s = 1'b1; nxt_s = S_LINE2; end
            S_LINE2: begin
                cur_byte_s  = hex_char(snap_nib_s);
                last_item_s = (idx_q == 4'd15);
                nxt_s       = S_IDLE;
            end
            default: begin cur_byte_s = 8'h00; last_item_s = 1'b0; end
        endcase
        cur_nib_s = half_q ? cur_byte_s[3:0] : cur_byte_s[7:4];
        if (ph_q != PH_WT) begin
            ph_lim_s = 32'(E_CYC);
        end else if (cur_byte_s == 8'h01 && !single_s) begin
            ph_lim_s = 32'(CLR_CYC);
        end else begin
            ph_lim_s = 32'(CMD_CYC);
        end
        ph_done_s = (cnt_q == ph_lim_s - 32'd1);
    end

    // Effective page, its live contents, and the redraw condition
    always_comb begin
        if (auto_rotate) begin
            eff_s = rot_q;
        end else if ({1'b0, page_sel} < 4'(NPAGE)) begin
            eff_s = page_sel;
        end else begin
            eff_s = 3'd0;
        end
        live_s  = 128'(page_data >> {eff_s, 7'd0});
        start_s = first_q || (eff_s != cur_page_q) || (live_s != snap_q);
    end

    // Rotation dwell timer; frozen while auto_rotate is low
    always_comb begin
        rot_d     = rot_q;
        rot_cnt_d = rot_cnt_q;
        if (auto_rotate) begin
            if (rot_cnt_q == 32'(HOLD_CYC - 1)) begin
                rot_cnt_d = 32'd0;
                rot_d     = (rot_q == 3'(NPAGE - 1)) ? 3'd0 : rot_q + 3'd1;
            end else begin
                rot_cnt_d = rot_cnt_q + 32'd1;
            end
        end else begin
            rot_cnt_d = rot_cnt_q;
        end
    end

    // Main sequencer: state, nibble phase and item index
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        half_d     = half_q;
        first_d    = first_q;
        cur_page_d = cur_page_q;
        snap_d     = snap_q;
        case (state_q)
            S_INIT_WAIT: begin
                if (cnt_q == 32'(INIT_CYC - 1)) begin
                    state_d = S_INIT_SEQ;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_IDLE: begin
                if (start_s) begin
                    state_d    = S_ADDR1;
                    cur_page_d = eff_s;
                    snap_d     = live_s;
                    first_d    = 1'b0;
                    cnt_d      = 32'd0;
                    idx_d      = 4'd0;
                    half_d     = 1'b0;
                    ph_d       = PH_SU;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT_SEQ, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2: begin
                if (!ph_done_s) begin
                    cnt_d = cnt_q + 32'd1;
                end else begin
                    cnt_d = 32'd0;
                    case (ph_q)
                        PH_SU: ph_d = PH_EH;
                        PH_EH: ph_d = PH_HD;
                        PH_HD: begin
                            if (!single_s && !half_q) begin
                                half_d = 1'b1;
                                ph_d   = PH_SU;
                            end else begin
                                ph_d = PH_WT;
                            end
                        end
                        PH_WT: begin
                            ph_d   = PH_SU;
                            half_d = 1'b0;
                            if (last_item_s) begin
                                idx_d   = 4'd0;
                                state_d = nxt_s;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end
                        default: ph_d = PH_SU;
                    endcase
                end
            end
            default: state_d = S_INIT_WAIT;
        endcase
    end

    // Bus values for the current phase; registered below
    always_comb begin
        send_s = (state_q != S_INIT_WAIT) && (state_q != S_IDLE);
        e_d    = send_s && (ph_q == PH_EH);
        dat_d  = (send_s && ph_q != PH_WT) ? cur_nib_s : 4'h0;
        rs_d   = (state_q == S_LINE1) || (state_q == S_LINE2);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT_WAIT;
            ph_q       <= PH_SU;
            cnt_q      <= 32'd0;
            idx_q      <= 4'd0;
            half_q     <= 1'b0;
            first_q    <= 1'b1;
            cur_page_q <= 3'd0;
            snap_q     <= 128'd0;
            rot_q      <= 3'd0;
            rot_cnt_q  <= 32'd0;
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            dat_q      <= 4'h0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            half_q     <= half_d;
            first_q    <= first_d;
            cur_page_q <= cur_page_d;
            snap_q     <= snap_d;
            rot_q      <= rot_d;
            rot_cnt_q  <= rot_cnt_d;
            e_q        <= e_d;
            rs_q       <= rs_d;
            dat_q      <= dat_d;
            busy_q     <= busy_d;
        end
    end

    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_dat  = dat_q;
    assign busy     = busy_q;
    assign cur_page = cur_page_q;

endmodule

// File: tb/tb_lcd_hex_pager.sv
// Bench for lcd_hex_pager: decodes the LCD bus into nibbles and compares frames
// against hex text built from the page words.
module tb_lcd_hex_pager;
    localparam int NP = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] page_data;
    logic [2:0]   page_sel;
    logic         auto_rotate;
    logic         lcd_e, lcd_rs, lcd_rw, busy;
    logic [3:0]   lcd_dat;
    logic [2:0]   cur_page;

    lcd_hex_pager #(.NPAGE(NP), .INIT_CYC(16), .E_CYC(2), .CMD_CYC(4),
                    .CLR_CYC(8), .HOLD_CYC(100)) dut (
        .clk(clk), .rst(rst), .page_data(page_data), .page_sel(page_sel),
        .auto_rotate(auto_rotate), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_dat(lcd_dat), .busy(busy), .cur_page(cur_page));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: one entry {rs,dat} per lcd_e rising edge
    logic [4:0] nib_q[$];
    int nib_cnt = 0;
    int bad_w = 0;
    int last_rise = 0;
    int rise_c[16];
    int fall_c[16];
    logic e_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                nib_q.delete();
                nib_cnt = 0;
                e_prev = 1'b0;
            end else begin
                if (lcd_e && !e_prev) begin
                    nib_q.push_back({lcd_rs, lcd_dat});
                    if (nib_cnt < 16) rise_c[nib_cnt] = cyc;
                    last_rise = cyc;
                end
                if (!lcd_e && e_prev) begin
                    if (cyc - last_rise != 2) bad_w++;
                    if (nib_cnt < 16) fall_c[nib_cnt] = cyc;
                    nib_cnt++;
                end
                e_prev = lcd_e;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got \"%s\" want \"%s\"", name, act, exp);
        end
    endtask

    function automatic string hexstr(input logic [31:0] w);
        string s;
        s = $sformatf("%08h", w);
        return s.toupper();
    endfunction

    function automatic logic [127:0] page_of(input logic [255:0] d, input int p);
        return 128'(d >> (128 * p));
    endfunction

    task automatic get_nib(output logic [4:0] v);
        int t = 0;
        while (nib_q.size() == 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (nib_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL nib_timeout: got no lcd_e pulse want one within 4000 clocks");
            v = 5'h1F;
        end else begin
            v = nib_q.pop_front();
        end
    endtask

    task automatic get_byte(output logic rs, output logic [7:0] b);
        logic [4:0] hi, lo;
        get_nib(hi);
        get_nib(lo);
        rs = hi[4] & lo[4];
        b = {hi[3:0], lo[3:0]};
    endtask

    task automatic read_line(output string s, output logic rs_all);
        logic rs;
        logic [7:0] b;
        s = "";
        rs_all = 1'b1;
        for (int i = 0; i < 16; i++) begin
            get_byte(rs, b);
            s = $sformatf("%s%c", s, b);
            rs_all = rs_all & rs;
        end
    endtask

    task automatic expect_frame(input logic [127:0] pg, input string name);
        logic rs, rs_all;
        logic [7:0] b;
        string s;
        get_byte(rs, b);
        chk({name, "_addr1"}, {rs, b}, {1'b0, 8'h80});
        read_line(s, rs_all);
        chk_s({name, "_line1"}, s, {hexstr(pg[31:0]), hexstr(pg[63:32])});
        get_byte(rs, b);
        chk({name, "_addr2"}, {rs, b}, {1'b0, 8'hC0});
        read_line(s, rs_all);
        chk_s({name, "_line2"}, s, {hexstr(pg[95:64]), hexstr(pg[127:96])});
        chk({name, "_rs_data"}, rs_all, 1'b1);
    endtask

    task automatic check_init(input string name);
        logic [4:0] n;
        logic rs;
        logic [7:0] b;
        logic [3:0] exp_n[4] = '{4'h3, 4'h3, 4'h3, 4'h2};
        logic [7:0] exp_b[4] = '{8'h28, 8'h0C, 8'h06, 8'h01};
        for (int i = 0; i < 4; i++) begin
            get_nib(n);
            chk($sformatf("%s_nib%0d", name, i), n, {1'b0, exp_n[i]});
        end
        for (int i = 0; i < 4; i++) begin
            get_byte(rs, b);
            chk($sformatf("%s_byte%0d", name, i), {rs, b}, {1'b0, exp_b[i]});
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (busy !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL %s_idle_timeout: busy got %b want 0", name, busy);
        end
    endtask

    int rel_cyc;
    task automatic timing_checks(input string name);
        int g;
        chk({name, "_init_wait"}, (rise_c[0] - rel_cyc >= 16), 1'b1);
        chk({name, "_gap_in_byte"}, 32'(rise_c[5] - fall_c[4]), 32'd4);
        chk({name, "_gap_cmd"}, 32'(rise_c[6] - fall_c[5]), 32'd8);
        g = rise_c[12] - fall_c[11];
        chk({name, "_gap_clear"}, (g >= 12 && g <= 14), 1'b1);
    endtask

    logic [2:0]   m_cur;
    logic [127:0] m_snap;

    task automatic do_step(input logic [2:0] sel, input logic [255:0] d,
                           input logic [2:0] exp_page, input logic exp_frame,
                           input string name);
        page_sel = sel;
        page_data = d;
        if (exp_frame) begin
            expect_frame(page_of(d, int'(exp_page)), name);
            wait_idle(name);
        end else begin
            repeat (60) @(negedge clk);
            chk({name, "_no_frame"}, {nib_q.size() == 0, busy}, 2'b10);
        end
        chk({name, "_cur_page"}, cur_page, exp_page);
        m_cur = exp_page;
        m_snap = page_of(d, int'(exp_page));
    endtask

    typedef struct packed {
        logic [2:0]   sel;
        logic [255:0] data;
        logic [2:0]   exp_page;
        logic         exp_frame;
    } vec_t;

    localparam logic [127:0] P0  = {32'hFFFFFFFF, 32'h00000000, 32'h89ABCDEF, 32'h0123ABCD};
    localparam logic [127:0] P0B = {32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h0123ABCD};
    localparam logic [127:0] P1  = {32'h55667788, 32'h11223344, 32'hCAFEF00D, 32'h13579BDF};

    initial begin
        vec_t vecs[6];
        string names[6];
        logic [255:0] d;
        logic [2:0] sel, eff;
        logic fr, rs;
        logic [7:0] b;
        int t, t0, bitpos;
        logic [2:0] rot_exp[2] = '{3'd1, 3'd0};

        vecs[0] = '{3'd0, {P1, P0},          3'd0, 1'b0}; names[0] = "static";
        vecs[1] = '{3'd0, {P1, P0B},         3'd0, 1'b1}; names[1] = "word1_change";
        vecs[2] = '{3'd5, {P1, P0B},         3'd0, 1'b0}; names[2] = "sel5_oob";
        vecs[3] = '{3'd1, {P1, P0B},         3'd1, 1'b1}; names[3] = "sel1";
        vecs[4] = '{3'd7, {P1, P0B},         3'd0, 1'b1}; names[4] = "sel7_oob";
        vecs[5] = '{3'd0, {P1 ^ 128'd1, P0B}, 3'd0, 1'b0}; names[5] = "hidden_page";

        rst = 1'b1;
        page_data = {P1, P0};
        page_sel = 3'd0;
        auto_rotate = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {lcd_e, lcd_rs, lcd_rw, lcd_dat, busy, cur_page},
            {1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd0});
        rst = 1'b0;
        rel_cyc = cyc;

        check_init("init");
        expect_frame(P0, "first_frame");
        wait_idle("first_frame");
        chk("first_cur_page", cur_page, 3'd0);
        timing_checks("init");
        m_cur = 3'd0;
        m_snap = P0;

        for (int i = 0; i < 6; i++)
            do_step(vecs[i].sel, vecs[i].data, vecs[i].exp_page, vecs[i].exp_frame, names[i]);

        // Data changed twice: second change lands mid-frame, shown by the next frame
        d = page_data;
        d[31:0] = 32'hDEADBEEF;
        page_data = d;
        t = 0;
        while (busy !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        repeat (100) @(negedge clk);
        d[31:0] = 32'h11112222;
        page_data = d;
        expect_frame(page_of({P1 ^ 128'd1, P0B[127:32], 32'hDEADBEEF}, 0), "midframe_old");
        expect_frame(page_of(d, 0), "midframe_new");
        wait_idle("midframe");
        m_cur = 3'd0;
        m_snap = page_of(d, 0);

        for (int i = 0; i < 12; i++) begin
            sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                bitpos = 128 * $urandom_range(0, 1) + 32 * $urandom_range(0, 3);
                d = (d & ~(256'hFFFFFFFF << bitpos)) | (256'($urandom) << bitpos);
            end
            eff = (sel < 3'(NP)) ? sel : 3'd0;
            fr = (eff != m_cur) || (page_of(d, int'(eff)) != m_snap);
            do_step(sel, d, eff, fr, $sformatf("rand%0d", i));
        end

        fr = (m_cur != 3'd0) || (page_of(d, 0) != m_snap);
        do_step(3'd0, d, 3'd0, fr, "pre_rotate");

        auto_rotate = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 2; i++) begin
            t = 0;
            while (busy !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
            if (i == 0) chk("rotate_dwell", ((cyc - t0) >= 98 && (cyc - t0) <= 104), 1'b1);
            chk($sformatf("rotate_page%0d", i), cur_page, rot_exp[i]);
            expect_frame(page_of(d, int'(rot_exp[i])), $sformatf("rotate%0d", i));
            t = 0;
            while (busy !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        end
        auto_rotate = 1'b0;
        repeat (1500) @(negedge clk);
        nib_q.delete();
        chk("auto_off_idle", busy, 1'b0);

        // Reset while LINE2 character 5 is on the bus
        d[0] = ~d[0];
        d[128] = ~d[128];
        page_data = d;
        for (int i = 0; i < 22; i++) get_byte(rs, b);
        t = 0;
        while (nib_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
        chk("line2_char5_seen", (nib_q.size() != 0), 1'b1);
        rst = 1'b1;
        #1;
        chk("midframe_reset", {lcd_e, lcd_rs, lcd_rw, lcd_dat, busy, cur_page},
            {1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd0});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        check_init("reinit");
        expect_frame(page_of(d, 0), "reinit_frame");
        wait_idle("reinit_frame");
        timing_checks("reinit");

        chk("e_high_width", 32'(bad_w), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
